// File: rtl/call_dispatcher.sv
// call_dispatcher: latches hall calls from the switch bank, picks the next
// target floor with a direction-preserving sweep, offers it to the car
// controller over a valid/ack handshake and clears calls on arrival.
// Optional feature: define CALL_CANCEL_EN to let a re-press of a pending
// call cancel it (except the floor currently offered or being served).
module call_dispatcher #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = 4
) (
  input  logic               CLOCK_50,
  input  logic               RST_N,
  input  logic [FLOORS-1:0]  call_req,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               car_idle,
  input  logic               arrive,
  input  logic               target_ack,
  output logic [FLOOR_W-1:0] target,
  output logic               target_valid,
  output logic               dir_up,
  output logic [FLOORS-1:0]  pending,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_OFFER  = 2'd2,
    S_MOVING = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [FLOORS-1:0]    call_prev_q;
  logic [FLOORS-1:0]    pending_q, pending_d;
  logic [FLOOR_W-1:0]   target_q, target_d;
  logic                 valid_q, valid_d;
  logic                 dir_q, dir_d;

  logic [FLOORS-1:0]    new_call;
  logic [FLOORS-1:0]    clr_mask;
  logic [FLOORS-1:0]    cancel_mask;
  logic [FLOORS-1:0]    cur_onehot;

  logic                 hit_cur;
  logic                 up_found, dn_found;
  logic [FLOOR_W-1:0]   up_floor, dn_floor;

`ifdef CALL_CANCEL_EN
  logic [FLOORS-1:0]    protect_mask;
`endif

  // Call bookkeeping: rising-edge set, arrival clear (clear beats set), optional cancel.
  always_comb begin
    new_call    = call_req & ~call_prev_q;
    clr_mask    = '0;
    cur_onehot  = '0;
    cancel_mask = '0;
    // cur_floor beyond the served range matches no bit, so nothing is cleared
    for (int i = 0; i < FLOORS; i++) begin
      cur_onehot[i] = (int'(cur_floor) == i);
      clr_mask[i]   = arrive && (int'(cur_floor) == i);
    end
`ifdef CALL_CANCEL_EN
    protect_mask = '0;
    // the floor already handed to the car must not vanish under it
    for (int i = 0; i < FLOORS; i++) begin
      protect_mask[i] = ((state_q == S_OFFER) || (state_q == S_MOVING)) &&
                        (int'(target_q) == i);
    end
    cancel_mask = new_call & pending_q & ~protect_mask;
`endif
    pending_d = (pending_q | new_call) & ~clr_mask & ~cancel_mask;
  end

  // Sweep candidates, taken from the post-update call set so a call cleared
  // or cancelled in the SELECT cycle is never chosen.
  always_comb begin
    hit_cur  = |(pending_d & cur_onehot);
    up_found = 1'b0;
    dn_found = 1'b0;
    up_floor = '0;
    dn_floor = '0;
    // descending scan: the last hit is the lowest floor above the car
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (pending_d[i] && (i > int'(cur_floor))) begin
        up_found = 1'b1;
        up_floor = FLOOR_W'(i);
      end
    end
    // ascending scan: the last hit is the highest floor below the car
    for (int i = 0; i < FLOORS; i++) begin
      if (pending_d[i] && (i < int'(cur_floor))) begin
        dn_found = 1'b1;
        dn_floor = FLOOR_W'(i);
      end
    end
  end

  // Dispatch FSM next state, target choice and direction update.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if ((pending_q != '0) && car_idle) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (pending_d == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OFFER;
          if (hit_cur) begin
            target_d = cur_floor;
          end else if (dir_q) begin
            if (up_found) begin
              target_d = up_floor;
            end else begin
              dir_d    = 1'b0;
              target_d = dn_floor;
            end
          end else begin
            if (dn_found) begin
              target_d = dn_floor;
            end else begin
              dir_d    = 1'b1;
              target_d = up_floor;
            end
          end
        end
      end
      S_OFFER: begin
        if (target_ack) state_d = S_MOVING;
      end
      S_MOVING: begin
        if (arrive) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    valid_d = (state_d == S_OFFER);
  end

  // State and output registers; reset drops any offer and all calls.
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      call_prev_q <= call_req;  // a switch held through reset is not a call
      target_q    <= '0;
      valid_q     <= 1'b0;
      dir_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      call_prev_q <= call_req;
      target_q    <= target_d;
      valid_q     <= valid_d;
      dir_q       <= dir_d;
    end
  end

  assign target       = target_q;
  assign target_valid = valid_q;
  assign dir_up       = dir_q;
  assign pending      = pending_q;
  assign busy         = (state_q != S_IDLE);

endmodule
